// File: rtl/golomb_job_scheduler_if.sv
// golomb_job_scheduler_if: host-side job and result handshakes of the
// Golomb job scheduler. The host drives through the master modport; the
// scheduler attaches through the slave modport.
interface golomb_job_scheduler_if #(
   parameter int NUMPOSITIONS = 5,
   parameter int VALBITS      = 9
);
   localparam int W = (NUMPOSITIONS + 1) * VALBITS;

   logic         job_valid;
   logic         job_ready;
   logic [W-1:0] job_prefix;

   logic         res_valid;
   logic         res_ready;
   logic [5:0]   res_count;
   logic [W-1:0] res_marks;
   logic [31:0]  res_cycles;
   logic         res_timeout;

   modport master (
      output job_valid, job_prefix, res_ready,
      input  job_ready, res_valid, res_count, res_marks, res_cycles, res_timeout
   );

   modport slave (
      input  job_valid, job_prefix, res_ready,
      output job_ready, res_valid, res_count, res_marks, res_cycles, res_timeout
   );
endinterface

// File: rtl/golomb_job_scheduler.sv
// golomb_job_scheduler: sequences one mark_counter_assembly through a stream
// of ruler-prefix jobs. Each job loads the prefix, holds the assembly in reset
// for RSTCYCLES cycles, runs it until done and reports numResults, the ruler
// seen just before the last numResults change and the run-cycle count.
// Optional run-cycle budget (MAXCYCLES): define JOB_TIMEOUT_EN.
module golomb_job_scheduler #(
   parameter int          NUMPOSITIONS = 5,
   parameter int          VALBITS      = 9,
   parameter int          RSTCYCLES    = 2,
   parameter logic [31:0] MAXCYCLES    = 32'hFFFF_FFFF
) (
   input  logic                                 clock,
   input  logic                                 reset,
   golomb_job_scheduler_if.slave                host,
   output logic                                 asm_reset,
   output logic [(NUMPOSITIONS+1)*VALBITS-1:0]  asm_firstvalues,
   input  logic                                 asm_done,
   input  logic [(NUMPOSITIONS+1)*VALBITS-1:0]  asm_marks,
   input  logic [5:0]                           asm_num_results,
   output logic                                 busy,
   output logic [15:0]                          jobs_done
);
   localparam int W = (NUMPOSITIONS + 1) * VALBITS;

   typedef enum logic [1:0] {IDLE, LOAD, RUN, REPORT} state_t;

   state_t       state_reg, state_next;
   logic [3:0]   rcnt_reg;
   logic [31:0]  cyc_reg;
   logic [5:0]   num_dly_reg;
   logic [W-1:0] prev_marks_reg;
   logic [W-1:0] cap_marks_reg, cap_marks_next;
   logic [W-1:0] firstvalues_reg;
   logic         res_valid_reg;
   logic [5:0]   res_count_reg;
   logic [W-1:0] res_marks_reg;
   logic [31:0]  res_cycles_reg;
   logic [15:0]  jobs_done_reg;
   logic         accept, done_seen, budget_hit, release_res;
`ifdef JOB_TIMEOUT_EN
   logic         res_timeout_reg;
`endif

   // Next state, handshake strobes and state-decoded outputs
   always_comb begin
      state_next     = state_reg;
      accept         = 1'b0;
      done_seen      = 1'b0;
      budget_hit     = 1'b0;
      release_res    = 1'b0;
      host.job_ready = 1'b0;
      // A numResults change in the same cycle as done must still be captured,
      // so the report path uses this look-ahead value, not cap_marks_reg.
      cap_marks_next = (asm_num_results != num_dly_reg) ? prev_marks_reg : cap_marks_reg;
      case (state_reg)
         IDLE: begin
            host.job_ready = !reset;
            accept         = host.job_valid && !reset;
            if (accept) state_next = LOAD;
         end
         LOAD: begin
            // done is deliberately ignored here: it may be stale from the last job
            if (rcnt_reg == 4'd1) state_next = RUN;
         end
         RUN: begin
            // cyc only reads zero on the first RUN cycle (it saturates, never wraps)
            done_seen = asm_done && (cyc_reg != 32'd0);
`ifdef JOB_TIMEOUT_EN
            budget_hit = !done_seen && (cyc_reg == MAXCYCLES - 32'd1);
`endif
            if (done_seen || budget_hit) state_next = REPORT;
         end
         REPORT: begin
            release_res = host.res_ready;
            if (release_res) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
      asm_reset = reset || (state_reg == LOAD);
      busy      = (state_reg != IDLE);
   end

   // State register
   always_ff @(posedge clock) begin
      if (reset) state_reg <= IDLE;
      else       state_reg <= state_next;
   end

   // Job datapath: prefix latch, reset counter, run counter, capture and results
   always_ff @(posedge clock) begin
      if (reset) begin
         rcnt_reg        <= '0;
         cyc_reg         <= '0;
         num_dly_reg     <= '0;
         prev_marks_reg  <= '0;
         cap_marks_reg   <= '0;
         firstvalues_reg <= '0;
         res_valid_reg   <= 1'b0;
         res_count_reg   <= '0;
         res_marks_reg   <= '0;
         res_cycles_reg  <= '0;
         jobs_done_reg   <= '0;
`ifdef JOB_TIMEOUT_EN
         res_timeout_reg <= 1'b0;
`endif
      end else begin
         prev_marks_reg <= asm_marks;
         case (state_reg)
            IDLE: begin
               if (accept) begin
                  firstvalues_reg <= host.job_prefix;
                  cap_marks_reg   <= '0;
                  rcnt_reg        <= 4'(RSTCYCLES);
               end
            end
            LOAD: begin
               rcnt_reg <= rcnt_reg - 4'd1;
               if (rcnt_reg == 4'd1) begin
                  cyc_reg     <= '0;
                  num_dly_reg <= '0;
               end
            end
            RUN: begin
               if (cyc_reg != 32'hFFFF_FFFF) cyc_reg <= cyc_reg + 32'd1;
               num_dly_reg   <= asm_num_results;
               cap_marks_reg <= cap_marks_next;
               if (done_seen) begin
                  res_valid_reg   <= 1'b1;
                  res_count_reg   <= asm_num_results;
                  res_marks_reg   <= cap_marks_next;
                  res_cycles_reg  <= cyc_reg;
`ifdef JOB_TIMEOUT_EN
                  res_timeout_reg <= 1'b0;
`endif
               end
`ifdef JOB_TIMEOUT_EN
               else if (budget_hit) begin
                  res_valid_reg   <= 1'b1;
                  res_count_reg   <= asm_num_results;
                  res_marks_reg   <= cap_marks_next;
                  res_cycles_reg  <= MAXCYCLES;
                  res_timeout_reg <= 1'b1;
               end
`endif
            end
            REPORT: begin
               if (release_res) begin
                  res_valid_reg <= 1'b0;
                  jobs_done_reg <= jobs_done_reg + 16'd1;
               end
            end
            default: ;
         endcase
      end
   end

   assign asm_firstvalues = firstvalues_reg;
   assign jobs_done       = jobs_done_reg;
   assign host.res_valid  = res_valid_reg;
   assign host.res_count  = res_count_reg;
   assign host.res_marks  = res_marks_reg;
   assign host.res_cycles = res_cycles_reg;
`ifdef JOB_TIMEOUT_EN
   assign host.res_timeout = res_timeout_reg;
`else
   assign host.res_timeout = 1'b0;
`endif
endmodule

// File: tb/tb_golomb_job_scheduler.sv
// tb_golomb_job_scheduler: directed jobs against golomb_job_scheduler. The
// bench plays the assembly (numResults steps at chosen RUN cycles, marks as a
// function of the RUN cycle) and predicts every output from the job timeline:
// accept at cycle a, reset high a+1..a+R, RUN cycle k at a+R+1+k, result one
// cycle after done. Timeout jobs run only when JOB_TIMEOUT_EN is defined.
`timescale 1ns/1ps
module tb_golomb_job_scheduler;
   localparam int          NP   = 5;
   localparam int          VB   = 9;
   localparam int          W    = (NP + 1) * VB;
   localparam int          R    = 2;
   localparam logic [31:0] MAXC = 32'd100;
   localparam int          NONE = 1 << 30;

   typedef struct {
      logic [W-1:0] prefix;
      int c1, c2, d, salt, hold, rst_at, pin;
      bit stale;
   } job_t;

   logic clock = 1'b0;
   logic reset = 1'b1;
   always #5 clock = ~clock;

   golomb_job_scheduler_if #(.NUMPOSITIONS(NP), .VALBITS(VB)) host();
   logic         asm_reset, asm_done, busy;
   logic [W-1:0] asm_firstvalues, asm_marks;
   logic [5:0]   asm_num_results;
   logic [15:0]  jobs_done;

   golomb_job_scheduler #(.NUMPOSITIONS(NP), .VALBITS(VB), .RSTCYCLES(R), .MAXCYCLES(MAXC)) dut (
      .clock(clock), .reset(reset), .host(host),
      .asm_reset(asm_reset), .asm_firstvalues(asm_firstvalues), .asm_done(asm_done),
      .asm_marks(asm_marks), .asm_num_results(asm_num_results),
      .busy(busy), .jobs_done(jobs_done)
   );

   // expectations written by the stimulus, read by the compare process
   int           t = 0;
   bit           chk_en = 0, rst_phase = 0, res_chk = 0;
   logic         e_job_ready = 0, e_asm_reset = 1, e_busy = 0, e_res_valid = 0, e_timeout = 0;
   logic [15:0]  e_jobs_done = 0;
   logic [W-1:0] e_first = '0, e_marks = '0;
   logic [5:0]   e_count = '0;
   logic [31:0]  e_cycles = '0;
   int           pin_id = 0;
   int           checks = 0, failures = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, t);
      end
   endtask

   // Compare process: every cycle, away from the active edge
   always @(negedge clock) begin
      if (chk_en) begin
         chk("job_ready", 64'(host.job_ready), 64'(e_job_ready));
         chk("asm_reset", 64'(asm_reset), 64'(e_asm_reset));
         if (!rst_phase) begin
            chk("busy", 64'(busy), 64'(e_busy));
            chk("res_valid", 64'(host.res_valid), 64'(e_res_valid));
            chk("jobs_done", 64'(jobs_done), 64'(e_jobs_done));
            chk("asm_firstvalues", 64'(asm_firstvalues), 64'(e_first));
            if (res_chk) begin
               chk("res_count", 64'(host.res_count), 64'(e_count));
               chk("res_marks", 64'(host.res_marks), 64'(e_marks));
               chk("res_cycles", 64'(host.res_cycles), 64'(e_cycles));
               chk("res_timeout", 64'(host.res_timeout), 64'(e_timeout));
            end
            if (pin_id == 1 && e_res_valid) begin
               chk("pin1_count", 64'(host.res_count), 64'(6'd1));
               chk("pin1_cycles", 64'(host.res_cycles), 64'(32'd50));
               chk("pin1_marks", 64'(host.res_marks), 64'({9'd0, 9'd20, 9'd40, 9'd60, 9'd80, 9'd100}));
            end
            if (pin_id == 2 && e_res_valid) begin
               chk("pin2_count", 64'(host.res_count), 64'(6'd2));
               chk("pin2_cycles", 64'(host.res_cycles), 64'(32'd15));
               chk("pin2_marks", 64'(host.res_marks), 64'({9'd3, 9'd15, 9'd27, 9'd39, 9'd51, 9'd63}));
            end
         end
      end
   end

   // assembly model: mark i at RUN cycle k
   function automatic logic [W-1:0] mk(input int k, input int salt);
      logic [W-1:0] v;
      v = '0;
      for (int i = 0; i <= NP; i++) v[W-1-i*VB -: VB] = VB'(i * (k + 1) + salt);
      return v;
   endfunction

   function automatic logic [5:0] nr_at(input int k, input int c1, input int c2);
      return 6'((k >= c1 ? 1 : 0) + (k >= c2 ? 1 : 0));
   endfunction

   task automatic drive_asm(input int k, input job_t j);
      if (k < 0) begin
         asm_num_results = '0;
         asm_marks       = mk(777, j.salt);
         asm_done        = j.stale;
      end else begin
         asm_num_results = nr_at(k, j.c1, j.c2);
         asm_marks       = mk(k, j.salt);
         asm_done        = (k >= j.d) || (j.stale && k == 0);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
      t++;
   endtask

   task automatic exp_idle();
      e_job_ready = 1; e_asm_reset = 0; e_busy = 0; e_res_valid = 0;
   endtask

   task automatic run_job(input int id, input job_t j);
      int  end_k, lc;
      bit  to;
      // model: where the job ends and what it must report
      end_k = j.d; to = 0;
`ifdef JOB_TIMEOUT_EN
      if (j.d > int'(MAXC) - 1) begin end_k = int'(MAXC) - 1; to = 1; end
`endif
      lc = (j.c2 <= end_k) ? j.c2 : (j.c1 <= end_k) ? j.c1 : NONE;
      // offer
      host.job_valid = 1; host.job_prefix = j.prefix; drive_asm(-1, j);
      exp_idle();
      step();
      // LOAD: assembly held in reset, prefix latched, input bus scrambled
      host.job_valid = 0; host.job_prefix = ~j.prefix; e_first = j.prefix;
      e_job_ready = 0; e_busy = 1; e_asm_reset = 1;
      for (int i = 0; i < R; i++) begin drive_asm(-1, j); step(); end
      e_asm_reset = 0;
      // RUN
      for (int k = 0; k <= end_k; k++) begin
         drive_asm(k, j);
         if (k == j.rst_at) begin
            reset = 1; rst_phase = 1; e_job_ready = 0; e_asm_reset = 1;
            step();
            reset = 0; rst_phase = 0; drive_asm(-1, j);
            exp_idle(); e_jobs_done = 0; e_first = '0;
            e_count = '0; e_marks = '0; e_cycles = '0; e_timeout = 0; res_chk = 1;
            step();
            res_chk = 0;
            $display("job %0d: reset at RUN cycle %0d, discarded, jobs_done=%0d", id, k, jobs_done);
            return;
         end
         step();
      end
      // REPORT
      e_res_valid = 1; res_chk = 1; pin_id = j.pin;
      e_count   = nr_at(end_k, j.c1, j.c2);
      e_marks   = (lc == NONE) ? '0 : mk(lc - 1, j.salt);
      e_cycles  = to ? MAXC : 32'(end_k);
      e_timeout = to;
      for (int i = 0; i <= j.hold; i++) begin
         drive_asm(end_k + 1 + i, j);
         host.res_ready = (i == j.hold);
         step();
      end
      $display("job %0d: count=%0d cycles=%0d timeout=%0b marks=%0h", id,
               host.res_count, host.res_cycles, host.res_timeout, host.res_marks);
      host.res_ready = 0; res_chk = 0; pin_id = 0;
      exp_idle(); e_jobs_done = e_jobs_done + 16'd1;
      drive_asm(end_k + 2 + j.hold, j);
      step();
   endtask

   job_t jobs[8];

   initial begin
      //          prefix                                          c1    c2    d      salt hold rst   pin stale
      jobs[0] = '{{9'd0, 9'd1, 9'd2, 9'd3, 9'd4, 9'd5},           20,   NONE, 50,    0,   10,  NONE, 1,  0};
      jobs[1] = '{{9'd0, 9'd2, 9'd7, 9'd11, 9'd17, 9'd25},        5,    12,   15,    3,   0,   NONE, 2,  1};
      jobs[2] = '{{9'd0, 9'd1, 9'd4, 9'd9, 9'd15, 9'd22},         8,    30,   30,    7,   1,   NONE, 0,  0};
      jobs[3] = '{{9'd0, 9'd3, 9'd5, 9'd13, 9'd20, 9'd511},       10,   NONE, 60,    1,   0,   30,   0,  0};
      jobs[4] = '{{9'd0, 9'd6, 9'd9, 9'd10, 9'd300, 9'd400},      NONE, NONE, 1,     2,   0,   NONE, 0,  1};
      jobs[5] = '{{9'd1, 9'd2, 9'd3, 9'd5, 9'd8, 9'd13},          1,    NONE, 3,     5,   2,   NONE, 0,  0};
      jobs[6] = '{{9'd0, 9'd1, 9'd2, 9'd3, 9'd4, 9'd5},           40,   NONE, NONE,  4,   1,   NONE, 0,  0};
      jobs[7] = '{{9'd0, 9'd1, 9'd2, 9'd3, 9'd4, 9'd5},           10,   NONE, 99,    6,   0,   NONE, 0,  0};

      // reset for 3 cycles with a job offered
      host.job_valid = 1; host.job_prefix = '1; host.res_ready = 0;
      asm_done = 1; asm_num_results = 6'd3; asm_marks = '1;
      reset = 1; rst_phase = 1; chk_en = 1; e_job_ready = 0; e_asm_reset = 1;
      for (int i = 0; i < 3; i++) step();
      reset = 0; rst_phase = 0; host.job_valid = 0; asm_done = 0;
      exp_idle(); e_jobs_done = 0; e_first = '0; res_chk = 1;
      step();
      res_chk = 0;

      for (int n = 0; n < 6; n++) run_job(n, jobs[n]);
`ifdef JOB_TIMEOUT_EN
      for (int n = 6; n < 8; n++) run_job(n, jobs[n]);
`endif
      chk_en = 0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
